// File: rtl/button_pulse_gen.sv
// Debounced multi-channel key interface: synchronizes raw keys, debounces each one
// with its own FSM, and emits registered press/release/auto-repeat pulses.
module button_pulse_gen #(
   parameter int N_BTN        = 2,
   parameter int DB_CYCLES    = 4,
   parameter int REPEAT_DELAY = 8,
   parameter int REPEAT_RATE  = 3,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [N_BTN-1:0] btn_in,
   input  logic [N_BTN-1:0] repeat_en,
   output logic [N_BTN-1:0] level,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse,
   output logic             pulse_any
);

   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int DB_W     = $clog2(DB_CYCLES + 1);
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   typedef enum logic [1:0] {RELEASED, PRESS_DB, HELD, RELEASE_DB} state_t;

   logic [N_BTN-1:0]  pressed_raw;
   logic [N_BTN-1:0]  sync1;
   logic [N_BTN-1:0]  sync2;
   logic [N_BTN-1:0]  press_nxt;
   logic [N_BTN-1:0]  rep;
   state_t            state    [N_BTN];
   logic [DB_W-1:0]   db_cnt   [N_BTN];
   logic [HOLD_W-1:0] hold_cnt [N_BTN];

   assign pressed_raw = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

   function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] c);
      return (int'(c) >= DB_CYCLES) ? c : c + 1'b1;
   endfunction

   function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] c);
      return (int'(c) >= HOLD_MAX) ? c : c + 1'b1;
   endfunction

   // Press pulse decision: debounce completion, or a repeat interval expiring while held.
   function automatic logic press_event(input state_t st, input logic s,
                                        input logic [DB_W-1:0] dc,
                                        input logic [HOLD_W-1:0] hc,
                                        input logic r, input logic en);
      case (st)
         RELEASED: return s && (DB_CYCLES == 1);
         PRESS_DB: return s && (int'(dc) + 1 >= DB_CYCLES);
         HELD:     return s && en && (int'(hc) + 1 >= (r ? REPEAT_RATE : REPEAT_DELAY));
         default:  return 1'b0;
      endcase
   endfunction

   always_comb begin
      press_nxt = '0;
      for (int i = 0; i < N_BTN; i++)
         press_nxt[i] = press_event(state[i], sync2[i], db_cnt[i], hold_cnt[i],
                                    rep[i], repeat_en[i]);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1         <= '0;
         sync2         <= '0;
         level         <= '0;
         press_pulse   <= '0;
         release_pulse <= '0;
         pulse_any     <= 1'b0;
         rep           <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            state[i]    <= RELEASED;
            db_cnt[i]   <= '0;
            hold_cnt[i] <= '0;
         end
      end else begin
         sync1         <= pressed_raw;
         sync2         <= sync1;
         press_pulse   <= press_nxt;
         pulse_any     <= |press_nxt;
         release_pulse <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            case (state[i])
               RELEASED: begin
                  if (sync2[i]) begin
                     if (press_nxt[i]) begin
                        state[i]    <= HELD;
                        level[i]    <= 1'b1;
                        hold_cnt[i] <= '0;
                        rep[i]      <= 1'b0;
                     end else begin
                        state[i]  <= PRESS_DB;
                        db_cnt[i] <= DB_W'(1);
                     end
                  end
               end
               PRESS_DB: begin
                  if (!sync2[i]) begin
                     state[i]  <= RELEASED;
                     db_cnt[i] <= '0;
                  end else if (press_nxt[i]) begin
                     state[i]    <= HELD;
                     level[i]    <= 1'b1;
                     db_cnt[i]   <= '0;
                     hold_cnt[i] <= '0;
                     rep[i]      <= 1'b0;
                  end else begin
                     db_cnt[i] <= db_inc(db_cnt[i]);
                  end
               end
               HELD: begin
                  if (!sync2[i]) begin
                     hold_cnt[i] <= '0;
                     rep[i]      <= 1'b0;
                     if (DB_CYCLES == 1) begin
                        state[i]         <= RELEASED;
                        level[i]         <= 1'b0;
                        release_pulse[i] <= 1'b1;
                     end else begin
                        state[i]  <= RELEASE_DB;
                        db_cnt[i] <= DB_W'(1);
                     end
                  end else if (!repeat_en[i]) begin
                     // Dropping the enable forgets any partial wait; re-enabling starts from the long delay.
                     hold_cnt[i] <= '0;
                     rep[i]      <= 1'b0;
                  end else if (press_nxt[i]) begin
                     hold_cnt[i] <= '0;
                     rep[i]      <= 1'b1;
                  end else begin
                     hold_cnt[i] <= hold_inc(hold_cnt[i]);
                  end
               end
               default: begin
                  if (sync2[i]) begin
                     state[i]    <= HELD;
                     db_cnt[i]   <= '0;
                     hold_cnt[i] <= '0;
                     rep[i]      <= 1'b0;
                  end else if (int'(db_cnt[i]) + 1 >= DB_CYCLES) begin
                     state[i]         <= RELEASED;
                     level[i]         <= 1'b0;
                     release_pulse[i] <= 1'b1;
                     db_cnt[i]        <= '0;
                  end else begin
                     db_cnt[i] <= db_inc(db_cnt[i]);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with default parameters (2 keys, active-low).
module tb_button_pulse_gen;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [1:0] btn_in;
   logic [1:0] repeat_en;
   logic [1:0] level;
   logic [1:0] press_pulse;
   logic [1:0] release_pulse;
   logic       pulse_any;

   int errors = 0;
   int checks = 0;

   button_pulse_gen #(
      .N_BTN(2), .DB_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_RATE(3), .ACTIVE_LOW(1)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .btn_in(btn_in),
      .repeat_en(repeat_en),
      .level(level),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse),
      .pulse_any(pulse_any)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".level"}, level, 2'b00);
      chk({tag, ".press"}, press_pulse, 2'b00);
      chk({tag, ".release"}, release_pulse, 2'b00);
      chk({tag, ".any"}, {1'b0, pulse_any}, 2'b00);
   endtask

   initial begin
      Reset     = 1'b1;
      btn_in    = 2'b11;
      repeat_en = 2'b00;
      step(); step(); step();
      chk_all_zero("reset");
      Reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk_all_zero("idle");
      end

      // Clean press of ch0 for 20 cycles, then release
      btn_in[0] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk("clean.press", press_pulse, (k == 6) ? 2'b01 : 2'b00);
         chk("clean.level", level, (k >= 6) ? 2'b01 : 2'b00);
         chk("clean.rel", release_pulse, 2'b00);
      end
      btn_in[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("clean.relpulse", release_pulse, (k == 6) ? 2'b01 : 2'b00);
         chk("clean.rellevel", level, (k < 6) ? 2'b01 : 2'b00);
         chk("clean.nopress", press_pulse, 2'b00);
      end
      for (int k = 1; k <= 4; k++) step();

      // Bounce: low 3, high 1, low 12, then high
      for (int k = 1; k <= 26; k++) begin
         btn_in[0] = ((k <= 3) || (k >= 5 && k <= 16)) ? 1'b0 : 1'b1;
         step();
         chk("bounce.press", press_pulse, (k == 10) ? 2'b01 : 2'b00);
         chk("bounce.rel", release_pulse, (k == 22) ? 2'b01 : 2'b00);
      end

      // Auto-repeat on ch1, held low for 30 cycles
      repeat_en = 2'b10;
      for (int k = 1; k <= 40; k++) begin
         btn_in[1] = (k <= 30) ? 1'b0 : 1'b1;
         step();
         if (k == 32)
            chk("repeat.ch0", {1'b0, press_pulse[0]}, 2'b00);
         else
            chk("repeat.press", press_pulse,
                (k == 6 || k == 14 || k == 17 || k == 20 || k == 23 || k == 26 || k == 29)
                ? 2'b10 : 2'b00);
         chk("repeat.rel", release_pulse, (k == 36) ? 2'b10 : 2'b00);
      end
      repeat_en = 2'b00;
      for (int k = 1; k <= 4; k++) step();

      // Both channels pressed on the same edge
      btn_in = 2'b00;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("both.press", press_pulse, (k == 6) ? 2'b11 : 2'b00);
         chk("both.any", {1'b0, pulse_any}, (k == 6) ? 2'b01 : 2'b00);
      end

      // Asynchronous reset between edges while ch0 is held
      #2;
      Reset     = 1'b1;
      btn_in[1] = 1'b1;
      #1;
      chk_all_zero("async_reset");
      for (int k = 1; k <= 3; k++) begin
         step();
         chk_all_zero("in_reset");
      end
      Reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("postreset.press", press_pulse, (k == 6) ? 2'b01 : 2'b00);
         chk("postreset.level", level, (k >= 6) ? 2'b01 : 2'b00);
      end

      // Enable repeat mid-hold, cancel it, then re-enable
      repeat_en[0] = 1'b1;
      for (int k = 9; k <= 19; k++) begin
         step();
         chk("reen.press", press_pulse, (k == 16 || k == 19) ? 2'b01 : 2'b00);
      end
      repeat_en[0] = 1'b0;
      for (int k = 20; k <= 26; k++) begin
         step();
         chk("cancel.press", press_pulse, 2'b00);
      end
      repeat_en[0] = 1'b1;
      for (int k = 27; k <= 35; k++) begin
         step();
         chk("restart.press", press_pulse, (k == 34) ? 2'b01 : 2'b00);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
